// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: shared command codes, FSM states and helpers for the system controller
package sys_ctrl_pkg;
  localparam logic [7:0] CMD_WR  = 8'hAA;
  localparam logic [7:0] CMD_RD  = 8'hBB;
  localparam logic [7:0] CMD_ALU = 8'hCC;
  localparam logic [7:0] CMD_NOP = 8'hDD;
  localparam logic [7:0] CMD_BWR = 8'hEE;
  localparam logic [7:0] CMD_BRD = 8'hEF;
  localparam int REG_A = 0;
  localparam int REG_B = 1;
  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_CNT, GET_DATA, GET_A, GET_B, GET_FUN,
    RD_ISSUE, RD_WAIT, ALU_WAIT, PUSH
  } state_t;
  function automatic int res_bytes(input int w);
    return (w + 7) / 8;
  endfunction
endpackage

// File: rtl/sys_ctrl_tx_serializer.sv
// sys_ctrl_tx_serializer: pushes a loaded word LSB byte first into the TX FIFO under backpressure
module sys_ctrl_tx_serializer #(
  parameter int NB = 2,
  parameter int CW = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [NB*8-1:0] word_i,
  input  logic [CW-1:0]  cnt_i,
  input  logic           fifo_full_i,
  output logic [7:0]     fifo_wr_data_o,
  output logic           fifo_wr_inc_o,
  output logic           done_o
);
  logic [NB*8-1:0] word_q, word_d;
  logic [CW-1:0] left_q, left_d;
  logic done_q, done_d, push;
  assign push = (left_q != '0) && !fifo_full_i;
  assign fifo_wr_data_o = word_q[7:0];
  assign fifo_wr_inc_o = push;
  assign done_o = done_q;
  // shift out one byte per accepted push; the head byte stays put while the FIFO is full
  always_comb begin
    word_d = load_i ? word_i : push ? word_q >> 8 : word_q;
    left_d = load_i ? cnt_i : push ? left_q - 1'b1 : left_q;
    done_d = push && left_q == CW'(1);
  end
  // serializer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      left_q <= '0;
      done_q <= 1'b0;
    end else begin
      word_q <= word_d;
      left_q <= left_d;
      done_q <= done_d;
    end
  end
endmodule

// File: rtl/sys_ctrl_burst.sv
// sys_ctrl_burst: UART command-frame controller driving register file, ALU and TX FIFO
module sys_ctrl_burst
  import sys_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [7:0]               RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  input  logic [7:0]               RD_DATA,
  input  logic                     RD_DATA_VLD,
  input  logic                     FIFO_FULL,
  output logic [3:0]               ALU_FUN,
  output logic                     ALU_EN,
  output logic                     ALU_CLK_EN,
  output logic [ADDR_WIDTH-1:0]    ADDR,
  output logic                     WR_EN,
  output logic                     RD_EN,
  output logic [7:0]               WR_DATA,
  output logic [7:0]               FIFO_WR_DATA,
  output logic                     FIFO_WR_INC,
  output logic                     CLK_DIV_EN,
  output logic                     FRAME_ERR
);
  localparam int NB = res_bytes(ALU_OUT_WIDTH);
  localparam int SW = NB * 8;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int AMAX = 2 ** ADDR_WIDTH;
  state_t state_q, state_d;
  logic [7:0] cmd_q, cmd_d, cnt_q, cnt_d, wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d;
  logic [3:0] alu_fun_q, alu_fun_d;
  logic alu_en_q, alu_en_d, alu_clk_en_q, alu_clk_en_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d, err_q, err_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic in_get, expire, ser_load, ser_done;
  logic [SW-1:0] ser_word;
  logic [CW-1:0] ser_cnt;
  assign in_get = state_q inside {GET_ADDR, GET_CNT, GET_DATA, GET_A, GET_B, GET_FUN};
  assign expire = (TIMEOUT_CYCLES != 0) && in_get && !RX_D_VLD && tmr_q == TW'(TIMEOUT_CYCLES - 1);
  assign {ALU_FUN, ALU_EN, ALU_CLK_EN, ADDR, WR_EN, RD_EN, WR_DATA, FRAME_ERR} =
         {alu_fun_q, alu_en_q, alu_clk_en_q, addr_q, wr_en_q, rd_en_q, wr_data_q, err_q};
  assign CLK_DIV_EN = 1'b1;
  sys_ctrl_tx_serializer #(.NB(NB), .CW(CW)) u_ser (
    .clk(CLK), .rst(RST), .load_i(ser_load), .word_i(ser_word), .cnt_i(ser_cnt),
    .fifo_full_i(FIFO_FULL), .fifo_wr_data_o(FIFO_WR_DATA), .fifo_wr_inc_o(FIFO_WR_INC), .done_o(ser_done)
  );
  // frame parser: next state, registered strobes and operand/address tracking
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    addr_d = addr_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;
    alu_clk_en_d = alu_clk_en_q;
    alu_en_d = 1'b0;
    wr_en_d = 1'b0;
    rd_en_d = 1'b0;
    err_d = 1'b0;
    ser_load = 1'b0;
    ser_word = '0;
    ser_cnt = '0;
    tmr_d = (RX_D_VLD || !in_get) ? '0 : tmr_q + 1'b1;
    case (state_q)
      IDLE: if (RX_D_VLD) begin
        cmd_d = RX_P_DATA;
        cnt_d = 8'd1;
        state_d = RX_P_DATA inside {CMD_WR, CMD_RD, CMD_BWR, CMD_BRD} ? GET_ADDR :
                  RX_P_DATA == CMD_ALU ? GET_A : RX_P_DATA == CMD_NOP ? GET_FUN : IDLE;
        err_d = !(RX_P_DATA inside {CMD_WR, CMD_RD, CMD_BWR, CMD_BRD, CMD_ALU, CMD_NOP});
      end
      GET_ADDR: if (RX_D_VLD) begin
        err_d = int'(RX_P_DATA) >= AMAX;
        ptr_d = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = err_d ? IDLE : cmd_q == CMD_WR ? GET_DATA : cmd_q == CMD_RD ? RD_ISSUE : GET_CNT;
      end
      GET_CNT: if (RX_D_VLD) begin
        err_d = RX_P_DATA == 8'd0;
        cnt_d = RX_P_DATA;
        state_d = err_d ? IDLE : cmd_q == CMD_BWR ? GET_DATA : RD_ISSUE;
      end
      GET_DATA: if (RX_D_VLD) begin
        wr_en_d = 1'b1;
        wr_data_d = RX_P_DATA;
        addr_d = ptr_q;
        ptr_d = ptr_q + 1'b1;
        cnt_d = cnt_q - 8'd1;
        state_d = cnt_q == 8'd1 ? IDLE : GET_DATA;
      end
      GET_A, GET_B: if (RX_D_VLD) begin
        wr_en_d = 1'b1;
        wr_data_d = RX_P_DATA;
        addr_d = state_q == GET_A ? ADDR_WIDTH'(REG_A) : ADDR_WIDTH'(REG_B);
        state_d = state_q == GET_A ? GET_B : GET_FUN;
      end
      GET_FUN: if (RX_D_VLD) begin
        alu_fun_d = RX_P_DATA[3:0];
        alu_en_d = 1'b1;
        alu_clk_en_d = 1'b1;
        state_d = ALU_WAIT;
      end
      RD_ISSUE: begin
        rd_en_d = 1'b1;
        addr_d = ptr_q;
        state_d = RD_WAIT;
      end
      RD_WAIT: if (RD_DATA_VLD) begin
        ser_load = 1'b1;
        ser_word = SW'(RD_DATA);
        ser_cnt = CW'(1);
        state_d = PUSH;
      end
      ALU_WAIT: if (ALU_OUT_VLD) begin
        ser_load = 1'b1;
        ser_word = SW'(ALU_OUT);
        ser_cnt = CW'(NB);
        alu_clk_en_d = 1'b0;
        state_d = PUSH;
      end
      PUSH: if (ser_done) begin
        ptr_d = ptr_q + 1'b1;
        cnt_d = cnt_q - 8'd1;
        state_d = (cmd_q inside {CMD_RD, CMD_BRD} && cnt_q != 8'd1) ? RD_ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (expire) begin
      err_d = 1'b1;
      state_d = IDLE;
    end
    if (RX_D_VLD && state_q inside {RD_ISSUE, RD_WAIT, ALU_WAIT, PUSH}) err_d = 1'b1;
  end
  // controller state and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cmd_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      addr_q <= '0;
      wr_data_q <= '0;
      alu_fun_q <= '0;
      alu_en_q <= 1'b0;
      alu_clk_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      err_q <= 1'b0;
      tmr_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      addr_q <= addr_d;
      wr_data_q <= wr_data_d;
      alu_fun_q <= alu_fun_d;
      alu_en_q <= alu_en_d;
      alu_clk_en_q <= alu_clk_en_d;
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      err_q <= err_d;
      tmr_q <= tmr_d;
    end
  end
endmodule

// File: tb/tb_sys_ctrl_burst.sv
// tb_sys_ctrl_burst: randomized frame bench with a frame-level reference model
module tb_sys_ctrl_burst;
  localparam int AW = 4, OW = 16, TO = 32;
  logic CLK = 0, RST = 1;
  logic [7:0] RX_P_DATA = 0, RD_DATA = 0;
  logic RX_D_VLD = 0, ALU_OUT_VLD = 0, RD_DATA_VLD = 0;
  logic [OW-1:0] ALU_OUT = 0;
  logic full_rand = 0, full_force = 0, rand_full_en = 0;
  logic FIFO_FULL;
  logic [3:0] ALU_FUN;
  logic ALU_EN, ALU_CLK_EN, WR_EN, RD_EN, FIFO_WR_INC, CLK_DIV_EN, FRAME_ERR;
  logic [AW-1:0] ADDR;
  logic [7:0] WR_DATA, FIFO_WR_DATA;
  int total = 0, bad = 0, cyc = 0, nerr = 0, viol = 0, err_cyc = 0, last_vld = 0;
  logic [7:0] rf [16], mm [16];
  logic [7:0] got_wa[$], got_wd[$], got_push[$], exp_wa[$], exp_wd[$], exp_push[$], fq[$];
  int got_wcyc[$];
  int exp_err;
  assign FIFO_FULL = full_rand | full_force;
  sys_ctrl_burst #(.ADDR_WIDTH(AW), .ALU_OUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .ALU_OUT(ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD), .RD_DATA(RD_DATA), .RD_DATA_VLD(RD_DATA_VLD), .FIFO_FULL(FIFO_FULL),
    .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .ALU_CLK_EN(ALU_CLK_EN), .ADDR(ADDR), .WR_EN(WR_EN),
    .RD_EN(RD_EN), .WR_DATA(WR_DATA), .FIFO_WR_DATA(FIFO_WR_DATA), .FIFO_WR_INC(FIFO_WR_INC),
    .CLK_DIV_EN(CLK_DIV_EN), .FRAME_ERR(FRAME_ERR)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f[1:0])
      2'd0: return 16'(a) + 16'(b);
      2'd1: return 16'(a) - 16'(b);
      2'd2: return 16'(a) * 16'(b);
      default: return {a, b};
    endcase
  endfunction
  always @(negedge CLK) begin
    if (WR_EN) begin
      got_wa.push_back(8'(ADDR));
      got_wd.push_back(WR_DATA);
      got_wcyc.push_back(cyc);
      rf[ADDR] = WR_DATA;
    end
    if (FIFO_WR_INC) begin
      got_push.push_back(FIFO_WR_DATA);
      if (FIFO_FULL) viol++;
    end
    if (FRAME_ERR) begin
      nerr++;
      err_cyc = cyc;
    end
  end
  initial forever begin
    @(negedge CLK);
    if (RD_EN) begin
      logic [7:0] d;
      d = rf[ADDR];
      repeat ($urandom_range(1, 3)) @(posedge CLK);
      #1 RD_DATA = d; RD_DATA_VLD = 1;
      @(posedge CLK);
      #1 RD_DATA_VLD = 0; RD_DATA = 8'($urandom);
    end
  end
  initial forever begin
    @(negedge CLK);
    if (ALU_EN) begin
      logic [15:0] r;
      r = alu_f(rf[0], rf[1], ALU_FUN);
      repeat ($urandom_range(1, 4)) @(posedge CLK);
      #1 ALU_OUT = r; ALU_OUT_VLD = 1;
      @(posedge CLK);
      #1 ALU_OUT_VLD = 0;
    end
  end
  initial forever begin
    @(posedge CLK);
    #1 full_rand = rand_full_en && ($urandom_range(0, 3) == 0);
  end
  task automatic mwr(input int a, input logic [7:0] d);
    exp_wa.push_back(8'(a % 16));
    exp_wd.push_back(d);
    mm[a % 16] = d;
  endtask
  task automatic mpush_alu(input logic [3:0] f);
    logic [15:0] r;
    r = alu_f(mm[0], mm[1], f);
    exp_push.push_back(r[7:0]);
    exp_push.push_back(r[15:8]);
  endtask
  task automatic model(input logic [7:0] f[$]);
    int a;
    exp_wa.delete(); exp_wd.delete(); exp_push.delete(); exp_err = 0;
    a = (f.size() > 1) ? int'(f[1]) : 0;
    case (f[0])
      8'hAA: if (a >= 16) exp_err = 1; else mwr(a, f[2]);
      8'hBB: if (a >= 16) exp_err = 1; else exp_push.push_back(mm[a]);
      8'hCC: begin mwr(0, f[1]); mwr(1, f[2]); mpush_alu(f[3][3:0]); end
      8'hDD: mpush_alu(f[1][3:0]);
      8'hEE: if (a >= 16 || f[2] == 0) exp_err = 1; else for (int i = 0; i < f[2]; i++) mwr(a + i, f[3+i]);
      8'hEF: if (a >= 16 || f[2] == 0) exp_err = 1; else for (int i = 0; i < f[2]; i++) exp_push.push_back(mm[(a + i) % 16]);
      default: exp_err = 1;
    endcase
  endtask
  task automatic send(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(posedge CLK);
    @(posedge CLK);
    #1 RX_P_DATA = b; RX_D_VLD = 1; last_vld = cyc;
    @(posedge CLK);
    #1 RX_D_VLD = 0;
  endtask
  task automatic clr();
    got_wa.delete(); got_wd.delete(); got_wcyc.delete(); got_push.delete(); nerr = 0;
  endtask
  task automatic run(input logic [7:0] f[$], input string tag);
    int n;
    model(f);
    clr();
    foreach (f[i]) send(f[i]);
    n = 0;
    while ((got_push.size() < exp_push.size() || got_wa.size() < exp_wa.size() || nerr < exp_err) && n < 3000) begin
      @(posedge CLK);
      n++;
    end
    repeat (6) @(posedge CLK);
    chk({tag, "_nwr"}, got_wa.size(), exp_wa.size());
    foreach (exp_wa[i]) if (i < got_wa.size()) begin
      chk({tag, "_wa"}, got_wa[i], exp_wa[i]);
      chk({tag, "_wd"}, got_wd[i], exp_wd[i]);
    end
    chk({tag, "_npush"}, got_push.size(), exp_push.size());
    foreach (exp_push[i]) if (i < got_push.size()) chk({tag, "_push"}, got_push[i], exp_push[i]);
    chk({tag, "_err"}, nerr, exp_err);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n, d;
    for (int i = 0; i < 16; i++) begin rf[i] = 8'($urandom); mm[i] = rf[i]; end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_outs", {ALU_FUN, ALU_EN, ALU_CLK_EN, ADDR, WR_EN, RD_EN, WR_DATA, FIFO_WR_DATA, FIFO_WR_INC, FRAME_ERR}, 0);
    chk("rst_clkdiv", CLK_DIV_EN, 1);
    @(posedge CLK); #1 RST = 0;
    run('{8'hAA, 8'h05, 8'h3C}, "wr");
    chk("wr_lat", got_wcyc.size() > 0 ? got_wcyc[0] - last_vld : -1, 1);
    run('{8'hBB, 8'h05}, "rd");
    chk("rd_3c", got_push.size() > 0 ? got_push[0] : 8'hFF, 8'h3C);
    run('{8'hEE, 8'h0E, 8'h03, 8'h11, 8'h22, 8'h33}, "bwr");
    run('{8'hCC, 8'h07, 8'h09, 8'h02}, "alu");
    chk("alu_fun", ALU_FUN, 2);
    chk("alu_clk_off", ALU_CLK_EN, 0);
    clr();
    fork
      run('{8'hEF, 8'h02, 8'h04}, "brd");
      begin
        n = 0;
        while (got_push.size() == 0 && n < 500) begin @(posedge CLK); n++; end
        #1 full_force = 1;
        repeat (10) @(posedge CLK);
        #1 full_force = 0;
      end
    join
    run('{8'h55}, "e_cmd");
    run('{8'hAA, 8'h20}, "e_addr");
    run('{8'hEE, 8'h00, 8'h00}, "e_cnt");
    clr();
    send(8'hAA); send(8'h03);
    n = 0;
    while (nerr == 0 && n < TO + 20) begin @(posedge CLK); n++; end
    repeat (4) @(posedge CLK);
    d = err_cyc - last_vld;
    chk("to_err", nerr, 1);
    chk("to_nwr", got_wa.size(), 0);
    chk("to_lat", (d >= TO && d <= TO + 2), 1);
    run('{8'hBB, 8'h03}, "after_to");
    clr();
    send(8'hEE); send(8'h04); send(8'h03); send(8'h11);
    @(posedge CLK); #1 RST = 1;
    @(posedge CLK);
    @(negedge CLK);
    chk("mrst_outs", {ALU_FUN, ALU_EN, ALU_CLK_EN, ADDR, WR_EN, RD_EN, WR_DATA, FIFO_WR_DATA, FIFO_WR_INC, FRAME_ERR}, 0);
    chk("mrst_clkdiv", CLK_DIV_EN, 1);
    @(posedge CLK); #1 RST = 0;
    repeat (20) @(posedge CLK);
    mm[4] = 8'h11;
    chk("mrst_nwr", got_wa.size(), 1);
    chk("mrst_wa", got_wa.size() > 0 ? got_wa[0] : 8'hFF, 8'h04);
    run('{8'hAA, 8'h02, 8'h77}, "post_rst");
    rand_full_en = 1;
    for (int t = 0; t < 40; t++) begin
      int k, c;
      logic [7:0] a;
      k = $urandom_range(0, 9);
      c = $urandom_range(1, 5);
      a = 8'($urandom_range(0, 15));
      case (k)
        0, 1: fq = '{8'hAA, a, 8'($urandom)};
        2: fq = '{8'hBB, a};
        3: fq = '{8'hCC, 8'($urandom), 8'($urandom), 8'($urandom_range(0, 15))};
        4: fq = '{8'hDD, 8'($urandom_range(0, 15))};
        5, 6: begin
          fq = '{8'hEE, a, 8'(c)};
          repeat (c) fq.push_back(8'($urandom));
        end
        7, 8: fq = '{8'hEF, a, 8'(c)};
        default: case ($urandom_range(0, 2))
          0: fq = '{8'($urandom_range(0, 8'h9F))};
          1: fq = '{8'hBB, 8'($urandom_range(16, 255))};
          default: fq = '{8'hEF, a, 8'h00};
        endcase
      endcase
      run(fq, "rnd");
    end
    rand_full_en = 0;
    chk("no_push_full", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
